// File: rtl/traffic_pkg.sv
// Shared phase encoding and lamp constants for the two-road traffic controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_1     = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_2     = 3'd5
  } phase_t;

  // Lamp vector layout is {ns_green, ns_yellow, ew_green, ew_yellow}.
  localparam logic [3:0] LIGHT_NS_G    = 4'b1000;
  localparam logic [3:0] LIGHT_NS_Y    = 4'b0100;
  localparam logic [3:0] LIGHT_ALL_RED = 4'b0000;
  localparam logic [3:0] LIGHT_EW_G    = 4'b0010;
  localparam logic [3:0] LIGHT_EW_Y    = 4'b0001;

endpackage

// File: rtl/traffic_timer.sv
// Phase timer: counts cycles in the current phase and flags the last one.
module traffic_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_duration,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_last;

  assign w_last = i_duration - CNT_W'(1);
  assign o_done = (r_count == w_last);

  // i_load restarts the count at the start of every new phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic.sv
// Fixed-time two-road intersection controller: green, yellow, all-red per road.
module traffic
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES  = 5,
  parameter int YELLOW_CYCLES = 2,
  parameter int RED_CYCLES    = 1,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] light
);

  phase_t           r_phase;
  phase_t           w_phase_next;
  logic [CNT_W-1:0] w_duration;
  logic             w_done;
  logic             w_load;

  traffic_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_duration (w_duration),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= NS_GREEN;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  // Duration and lamps depend on the phase register alone, keeping light glitch-free of the counter.
  always_comb begin
    w_duration = CNT_W'(RED_CYCLES);
    light      = LIGHT_ALL_RED;
    case (r_phase)
      NS_GREEN:  begin w_duration = CNT_W'(GREEN_CYCLES);  light = LIGHT_NS_G; end
      NS_YELLOW: begin w_duration = CNT_W'(YELLOW_CYCLES); light = LIGHT_NS_Y; end
      EW_GREEN:  begin w_duration = CNT_W'(GREEN_CYCLES);  light = LIGHT_EW_G; end
      EW_YELLOW: begin w_duration = CNT_W'(YELLOW_CYCLES); light = LIGHT_EW_Y; end
      default:   begin w_duration = CNT_W'(RED_CYCLES);    light = LIGHT_ALL_RED; end
    endcase
  end

  // Unknown encodings fall back to all-red with a fresh count.
  always_comb begin
    w_phase_next = r_phase;
    w_load       = w_done;
    case (r_phase)
      NS_GREEN:  if (w_done) w_phase_next = NS_YELLOW;
      NS_YELLOW: if (w_done) w_phase_next = RED_1;
      RED_1:     if (w_done) w_phase_next = EW_GREEN;
      EW_GREEN:  if (w_done) w_phase_next = EW_YELLOW;
      EW_YELLOW: if (w_done) w_phase_next = RED_2;
      RED_2:     if (w_done) w_phase_next = NS_GREEN;
      default: begin
        w_phase_next = RED_1;
        w_load       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic.sv
// Bench for traffic: three instances (default, 3/1/2, 1/1/1) against a cycle-arithmetic lamp model.
module tb_traffic;

  logic       clk;
  logic [2:0] rstN;
  logic [3:0] lightA, lightB, lightC;
  int         vectors     = 0;
  int         miscompares = 0;
  int         nA, nB, nC;

  traffic uA (.clk(clk), .rst_n(rstN[0]), .light(lightA));
  traffic #(.GREEN_CYCLES(3), .YELLOW_CYCLES(1), .RED_CYCLES(2), .CNT_W(8))
    uB (.clk(clk), .rst_n(rstN[1]), .light(lightB));
  traffic #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1), .RED_CYCLES(1), .CNT_W(8))
    uC (.clk(clk), .rst_n(rstN[2]), .light(lightC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of active edges each instance has seen since its reset was last released.
  always @(posedge clk or negedge rstN[0]) if (!rstN[0]) nA <= 0; else nA <= nA + 1;
  always @(posedge clk or negedge rstN[1]) if (!rstN[1]) nB <= 0; else nB <= nB + 1;
  always @(posedge clk or negedge rstN[2]) if (!rstN[2]) nC <= 0; else nC <= nC + 1;

  // Expected lamps after n edges: first half of the period is the NS road, second half EW.
  function automatic logic [3:0] expLight(int n, int g, int y, int r);
    int half;
    int m;
    logic [1:0] road;
    half = g + y + r;
    m = n % (2 * half);
    if (m >= half) m = m - half;
    if (m < g) road = 2'b10;
    else if (m < g + y) road = 2'b01;
    else road = 2'b00;
    if ((n % (2 * half)) < half) return {road, 2'b00};
    return {2'b00, road};
  endfunction

  function automatic logic [3:0] lightOf(int i);
    return (i == 0) ? lightA : (i == 1) ? lightB : lightC;
  endfunction

  function automatic logic [3:0] expOf(int i);
    if (i == 0) return expLight(nA, 5, 2, 1);
    if (i == 1) return expLight(nB, 3, 1, 2);
    return expLight(nC, 1, 1, 1);
  endfunction

  task automatic test_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (lightOf(i) !== 4'b1000) begin
        miscompares++;
        $display("[TB] FAIL reset_async inst=%0d light=%b expected=%b", i, lightOf(i), 4'b1000);
      end
    end
    @(negedge clk);
    vectors++;
    if (lightA !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL reset_held light=%b expected=%b", lightA, 4'b1000);
    end
    rstN = 3'b111;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (lightA !== 4'b1000) begin
        miscompares++;
        $display("[TB] FAIL reset_release edge=%0d light=%b expected=%b", nA, lightA, 4'b1000);
      end
    end
  endtask

  task automatic test_full_cycle();
    while (nA < 16) begin
      @(negedge clk);
      vectors++;
      if (lightA !== expLight(nA, 5, 2, 1)) begin
        miscompares++;
        $display("[TB] FAIL full_cycle edge=%0d light=%b expected=%b", nA, lightA, expLight(nA, 5, 2, 1));
      end
    end
    vectors++;
    if (lightA !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL full_cycle_wrap edge=%0d light=%b expected=%b", nA, lightA, 4'b1000);
    end
  endtask

  task automatic test_invariants();
    repeat (100) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        logic [3:0] l;
        l = lightOf(i);
        vectors++;
        if (!$onehot0(l) || (l[3:2] != 2'b00 && l[1:0] != 2'b00)) begin
          miscompares++;
          $display("[TB] FAIL invariant inst=%0d light=%b", i, l);
        end
        vectors++;
        if (l !== expOf(i)) begin
          miscompares++;
          $display("[TB] FAIL sequence inst=%0d light=%b expected=%b", i, l, expOf(i));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    guard = 0;
    while ((nA % 16) != 10 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if ((nA % 16) != 10 || lightA !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_setup edge=%0d light=%b expected=%b", nA, lightA, 4'b0010);
    end
    #2 rstN[0] = 1'b0;
    #1;
    vectors++;
    if (lightA !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_async light=%b expected=%b", lightA, 4'b1000);
    end
    @(negedge clk);
    rstN[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      vectors++;
      if (lightA !== ((k < 5) ? 4'b1000 : 4'b0100)) begin
        miscompares++;
        $display("[TB] FAIL mid_reset_green edge=%0d light=%b expected=%b", k, lightA,
                 (k < 5) ? 4'b1000 : 4'b0100);
      end
    end
  endtask

  task automatic test_params();
    repeat (30) begin
      @(negedge clk);
      vectors++;
      if (lightB !== expLight(nB, 3, 1, 2)) begin
        miscompares++;
        $display("[TB] FAIL params_3_1_2 edge=%0d light=%b expected=%b", nB, lightB, expLight(nB, 3, 1, 2));
      end
      vectors++;
      if (lightC !== expLight(nC, 1, 1, 1)) begin
        miscompares++;
        $display("[TB] FAIL params_1_1_1 edge=%0d light=%b expected=%b", nC, lightC, expLight(nC, 1, 1, 1));
      end
    end
  endtask

  task automatic test_random_reset();
    for (int it = 0; it < 25; it++) begin
      int which;
      which = $urandom_range(0, 2);
      repeat ($urandom_range(0, 30)) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          vectors++;
          if (lightOf(i) !== expOf(i)) begin
            miscompares++;
            $display("[TB] FAIL random_run inst=%0d light=%b expected=%b", i, lightOf(i), expOf(i));
          end
        end
      end
      @(negedge clk);
      #($urandom_range(1, 3));
      rstN[which] = 1'b0;
      #1;
      vectors++;
      if (lightOf(which) !== 4'b1000) begin
        miscompares++;
        $display("[TB] FAIL random_reset inst=%0d light=%b expected=%b", which, lightOf(which), 4'b1000);
      end
      @(negedge clk);
      rstN[which] = 1'b1;
    end
  endtask

  initial begin
    rstN = 3'b000;
    test_reset();
    test_full_cycle();
    test_invariants();
    test_mid_reset();
    test_params();
    test_random_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic.md
Name: traffic

Overview:
- Fixed-time controller for a two-road intersection (North-South, East-West).
- Cycles through green, yellow and all-red clearance phases for each road.
- Drives a 4-bit lamp vector to the signal-head drivers.
- Free-running: no sensor or request inputs.

Parameters:
- GREEN_CYCLES, 5, clock cycles a road shows green (>=1).
- YELLOW_CYCLES, 2, clock cycles a road shows yellow (>=1).
- RED_CYCLES, 1, all-red clearance cycles between roads (>=1).
- CNT_W, 8, phase counter width; must hold max(durations)-1.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- light  output  4  lamp vector {ns_green, ns_yellow, ew_green, ew_yellow}; a road is red when both of its bits are 0.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n, asynchronous and active-low.
- Phases, in order:
  - NS_GREEN (GREEN_CYCLES)
  - NS_YELLOW (YELLOW_CYCLES)
  - RED_1 (RED_CYCLES)
  - EW_GREEN (GREEN_CYCLES)
  - EW_YELLOW (YELLOW_CYCLES)
  - RED_2 (RED_CYCLES)
  - then wrap to NS_GREEN.
- Phase-to-output mapping (light is decoded combinationally from the phase register only, no counter dependency, so no extra latency):
  - NS_GREEN=4'b1000
  - NS_YELLOW=4'b0100
  - RED_1=4'b0000
  - EW_GREEN=4'b0010
  - EW_YELLOW=4'b0001
  - RED_2=4'b0000
- Reset (rst_n=0, async): phase=NS_GREEN, counter=0, light=4'b1000 immediately, without waiting for a clock edge. Held for the whole time rst_n is low.
- Each rising edge with rst_n=1:
  - If counter == duration(phase)-1: phase advances to the next phase and counter clears to 0.
  - Otherwise counter increments by 1.
- Timing from the first active edge after reset release (edge n):
  - light=1000 until edge 5, then 0100.
  - 0000 after edge 7; 0010 after edge 8.
  - 0001 after edge 13; 0000 after edge 15.
  - 1000 after edge 16. Period is 16 cycles with the defaults.
- Safety invariants:
  - Never both roads non-red simultaneously.
  - Never more than one bit of light set.
  - Green is always followed by yellow, and yellow by all-red.
- Illegal or unreachable phase encodings go to RED_1 with counter=0, so recovery is fail-safe all-red.
- Reset asserted mid-phase: immediate return to NS_GREEN with counter=0, from any phase and any count.
- Counter arithmetic is unsigned CNT_W bits and never wraps in legal operation.

Decomposition:
- Package traffic_pkg holds:
  - the phase enum (3-bit: NS_GREEN, NS_YELLOW, RED_1, EW_GREEN, EW_YELLOW, RED_2);
  - the lamp encoding constants LIGHT_NS_G, LIGHT_NS_Y, LIGHT_ALL_RED, LIGHT_EW_G, LIGHT_EW_Y.
- One sub-module, traffic_timer:
  - Inputs: clk, rst_n, load duration.
  - Output: done pulse when count reaches duration-1.
  - The top holds the phase FSM and the output decode.

Test Plan:
- Reset: rst_n=0 with clk idle -> light=4'b1000 with no clock edge; release and hold 4 edges -> still 4'b1000.
- Full cycle, default parameters: clock 16 edges after release -> sequence 1000x5, 0100x2, 0000x1, 0010x5, 0001x2, 0000x1; light=1000 again after edge 16.
- Invariant check over 100 cycles -> light is one-hot or zero every cycle, and ns bits and ew bits are never both non-zero.
- Mid-phase reset: assert rst_n=0 asynchronously during EW_GREEN, 2 cycles into the phase -> light=1000 at once; after release, a full 5-cycle NS green.
- Parameter override GREEN_CYCLES=3, YELLOW_CYCLES=1, RED_CYCLES=2 -> period 12; 1000x3, 0100x1, 0000x2, 0010x3, 0001x1, 0000x2.
- Minimum durations, all parameters=1 -> light changes on every edge through all 6 phases; period 6.
